// File: rtl/structure_tape_writer.sv
// Structure-tape writer: turns classified JSON elements into cross-linked 64-bit simdjson-style tape words.
// Define STRUCTURE_TAPE_ROOT_EN to frame each document with a pair of linked 'r' root words.

package Core;
    typedef enum logic [3:0] {
        str         = 4'd0,
        trueVal     = 4'd1,
        falseVal    = 4'd2,
        nullVal     = 4'd3,
        objOpen     = 4'd4,
        objClose    = 4'd5,
        arrayOpen   = 4'd6,
        arrayClose  = 4'd7,
        unsignedInt = 4'd8,
        signedInt   = 4'd9,
        doubleVal   = 4'd10
    } ElementType;

    function automatic logic [7:0] elementTypeToTapeChar(ElementType t);
        case (t)
            str:         return 8'h22;
            trueVal:     return 8'h74;
            falseVal:    return 8'h66;
            nullVal:     return 8'h6E;
            objOpen:     return 8'h7B;
            objClose:    return 8'h7D;
            arrayOpen:   return 8'h5B;
            arrayClose:  return 8'h5D;
            unsignedInt: return 8'h75;
            signedInt:   return 8'h6C;
            doubleVal:   return 8'h64;
            default:     return 8'h00;
        endcase
    endfunction
endpackage

module structure_tape_writer #(
    parameter int ADDR_W    = 12,
    parameter int MAX_DEPTH = 32,
    parameter int STR_IDX_W = 32,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  Core::ElementType     in_type,
    input  logic [STR_IDX_W-1:0] in_str_idx,
    input  logic [63:0]          in_num,
    input  logic                 in_last,
    output logic                 tape_we,
    output logic [ADDR_W-1:0]    tape_addr,
    output logic [63:0]          tape_wdata,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 done,
    output logic [ADDR_W:0]      tape_len,
    output logic                 err,
    output logic [2:0]           err_code
);
    import Core::*;

    typedef enum logic [3:0] {
        IDLE, ROOT_OPEN, RUN, PATCH, NUM2, ROOT_END, ROOT_PATCH, DONE, ERR
    } StateType;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    StateType          state;
    StateType          finState;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] patchAddr;
    logic [7:0]        patchPrefix;
    logic [63:0]       numReg;
    logic              lastPending;

    // Each stack entry holds {isObject, index of the open word}.
    logic [ADDR_W:0]   stackMem [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W-1:0] topIdx;
    logic [ADDR_W:0]   topEntry;

    logic              accept, isSimple, isOpen, isClose, isNum, wantObj, pushEn;
    logic [ADDR_W+1:0] needPtr;
    logic [2:0]        acceptErr, finCode;
    logic [55:0]       payload;
    logic [63:0]       elemWord;
    logic              finishNow;
    logic [ADDR_W:0]   finPtr;
    logic [DEPTH_W-1:0] finDepth;

    assign in_ready = (state == RUN);
    assign accept   = in_valid && (state == RUN) && !start;
    assign topIdx   = depth - 1'b1;
    assign topEntry = stackMem[topIdx];
    assign pushEn   = accept && (acceptErr == 3'd0) && isOpen;

    // Classify the incoming element and decide whether it can be taken without breaking the tape.
    always_comb begin
        isSimple = 1'b0;
        isOpen   = 1'b0;
        isClose  = 1'b0;
        isNum    = 1'b0;
        case (in_type)
            str, trueVal, falseVal, nullVal:    isSimple = 1'b1;
            objOpen, arrayOpen:                 isOpen   = 1'b1;
            objClose, arrayClose:               isClose  = 1'b1;
            unsignedInt, signedInt, doubleVal:  isNum    = 1'b1;
            default: ;
        endcase
        wantObj   = (in_type == objOpen) || (in_type == objClose);
        needPtr   = {1'b0, ptr} + (isNum ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));
        acceptErr = 3'd0;
        if (!(isSimple || isOpen || isClose || isNum))
            acceptErr = 3'd7;
        else if (isOpen && depth == DEPTH_W'(MAX_DEPTH))
            acceptErr = 3'd1;
        else if (isClose && depth == '0)
            acceptErr = 3'd2;
        else if (isClose && topEntry[ADDR_W] != wantObj)
            acceptErr = 3'd3;
        else if (needPtr > {1'b0, CAPACITY})
            acceptErr = 3'd4;

        payload = '0;
        if (in_type == str)
            payload = 56'(in_str_idx);
        else if (isClose)
            payload = 56'(topEntry[ADDR_W-1:0]);
        elemWord = {elementTypeToTapeChar(in_type), payload};
    end

    // Document completion: the last element's writes are finishing this cycle.
    always_comb begin
        finishNow = 1'b0;
        finPtr    = ptr;
        finDepth  = depth;
        if (!start) begin
            case (state)
                RUN: if (accept && acceptErr == 3'd0 && in_last && (isSimple || isOpen)) begin
                    finishNow = 1'b1;
                    finPtr    = ptr + 1'b1;
                    finDepth  = isOpen ? depth + 1'b1 : depth;
                end
                PATCH: finishNow = lastPending;
                NUM2: begin
                    finishNow = lastPending;
                    finPtr    = ptr + 1'b1;
                end
                default: ;
            endcase
        end
        finCode = 3'd0;
        if (finDepth != '0) begin
            finState = ERR;
            finCode  = 3'd5;
        end
`ifdef STRUCTURE_TAPE_ROOT_EN
        else if (finPtr == CAPACITY) begin
            finState = ERR;
            finCode  = 3'd4;
        end else
            finState = ROOT_END;
`else
        else
            finState = DONE;
`endif
    end

    always_ff @(posedge clk) begin
        if (pushEn)
            stackMem[depth] <= {wantObj, ptr[ADDR_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            depth       <= '0;
            patchAddr   <= '0;
            patchPrefix <= '0;
            numReg      <= '0;
            lastPending <= 1'b0;
            tape_we     <= 1'b0;
            tape_addr   <= '0;
            tape_wdata  <= '0;
            done        <= 1'b0;
            tape_len    <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            tape_we <= 1'b0;
            if (start) begin
                ptr         <= '0;
                depth       <= '0;
                done        <= 1'b0;
                tape_len    <= '0;
                err         <= 1'b0;
                err_code    <= '0;
                lastPending <= 1'b0;
`ifdef STRUCTURE_TAPE_ROOT_EN
                state       <= ROOT_OPEN;
`else
                state       <= RUN;
`endif
            end else begin
                case (state)
`ifdef STRUCTURE_TAPE_ROOT_EN
                    ROOT_OPEN: begin
                        tape_we    <= 1'b1;
                        tape_addr  <= '0;
                        tape_wdata <= {8'h72, 56'd0};
                        ptr        <= ptr + 1'b1;
                        state      <= RUN;
                    end
`endif
                    RUN: if (accept) begin
                        if (acceptErr != 3'd0) begin
                            err      <= 1'b1;
                            err_code <= acceptErr;
                            state    <= ERR;
                        end else begin
                            tape_we     <= 1'b1;
                            tape_addr   <= ptr[ADDR_W-1:0];
                            tape_wdata  <= elemWord;
                            ptr         <= ptr + 1'b1;
                            lastPending <= in_last;
                            if (isOpen)
                                depth <= depth + 1'b1;
                            if (isClose) begin
                                depth       <= depth - 1'b1;
                                patchAddr   <= topEntry[ADDR_W-1:0];
                                patchPrefix <= topEntry[ADDR_W] ? 8'h7B : 8'h5B;
                                state       <= PATCH;
                            end else if (isNum) begin
                                numReg <= in_num;
                                state  <= NUM2;
                            end
                        end
                    end
                    // ptr already points one past the close word, which is the link target.
                    PATCH: begin
                        tape_we    <= 1'b1;
                        tape_addr  <= patchAddr;
                        tape_wdata <= {patchPrefix, 56'(ptr)};
                        state      <= RUN;
                    end
                    NUM2: begin
                        tape_we    <= 1'b1;
                        tape_addr  <= ptr[ADDR_W-1:0];
                        tape_wdata <= numReg;
                        ptr        <= ptr + 1'b1;
                        state      <= RUN;
                    end
`ifdef STRUCTURE_TAPE_ROOT_EN
                    ROOT_END: begin
                        tape_we    <= 1'b1;
                        tape_addr  <= ptr[ADDR_W-1:0];
                        tape_wdata <= {8'h72, 56'd0};
                        ptr        <= ptr + 1'b1;
                        state      <= ROOT_PATCH;
                    end
                    ROOT_PATCH: begin
                        tape_we    <= 1'b1;
                        tape_addr  <= '0;
                        tape_wdata <= {8'h72, 56'(ptr)};
                        tape_len   <= ptr;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
`endif
                    default: ;
                endcase
                if (finishNow) begin
                    state <= finState;
                    if (finState == ERR) begin
                        err      <= 1'b1;
                        err_code <= finCode;
                    end
                    if (finState == DONE) begin
                        done     <= 1'b1;
                        tape_len <= finPtr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_structure_tape_writer.sv
// Scoreboard bench for structure_tape_writer: expected tape writes are queued as elements are driven
// and popped as the DUT strobes tape_we. Small parameters so full/overflow corners are reachable.

module tb_structure_tape_writer;
    import Core::*;

    localparam int ADDR_W    = 2;
    localparam int MAX_DEPTH = 2;
    localparam int STR_IDX_W = 32;
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    ElementType           in_type = str;
    logic [STR_IDX_W-1:0] in_str_idx = '0;
    logic [63:0]          in_num = '0;
    logic                 in_last = 1'b0;
    logic                 tape_we;
    logic [ADDR_W-1:0]    tape_addr;
    logic [63:0]          tape_wdata;
    logic [DEPTH_W-1:0]   depth;
    logic                 done;
    logic [ADDR_W:0]      tape_len;
    logic                 err;
    logic [2:0]           err_code;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } WriteRec;

    WriteRec expQ[$];
    int checks = 0;
    int failures = 0;

    structure_tape_writer #(.ADDR_W(ADDR_W), .MAX_DEPTH(MAX_DEPTH), .STR_IDX_W(STR_IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_str_idx(in_str_idx), .in_num(in_num), .in_last(in_last),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata), .depth(depth),
        .done(done), .tape_len(tape_len), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Every observed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        WriteRec e;
        if (rst_n && tape_we) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", tape_addr, tape_wdata);
            end else begin
                e = expQ.pop_front();
                if (tape_addr !== e.addr || tape_wdata !== e.data) begin
                    failures++;
                    $display("[TB] FAIL tape_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             tape_addr, tape_wdata, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [63:0] word(input logic [7:0] prefix, input logic [55:0] pl);
        return {prefix, pl};
    endfunction

    task automatic pushExp(input int a, input logic [63:0] d);
        WriteRec r;
        r.addr = ADDR_W'(a);
        r.data = d;
        expQ.push_back(r);
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef STRUCTURE_TAPE_ROOT_EN
        pushExp(0, word(8'h72, 56'd0));
`endif
    endtask

    task automatic sendElem(input ElementType t, input logic [31:0] idx, input logic [63:0] num, input logic last);
        int n;
        n = 0;
        in_type    = t;
        in_str_idx = idx;
        in_num     = num;
        in_last    = last;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (n >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected 1");
        end
    endtask

    task automatic waitSettle();
        for (int i = 0; i < 20 && !(done || err); i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks += 6;
        if (tape_we !== 1'b0)   begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", tape_we); end
        if (tape_wdata !== '0)  begin failures++; $display("[TB] FAIL reset_wdata: got %h expected 0", tape_wdata); end
        if (in_ready !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", in_ready); end
        if (done !== 1'b0)      begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (err !== 1'b0 || err_code !== 3'd0) begin failures++; $display("[TB] FAIL reset_err: got %b/%0d expected 0/0", err, err_code); end
        if (depth !== '0 || tape_len !== '0) begin failures++; $display("[TB] FAIL reset_counts: got depth=%0d len=%0d expected 0/0", depth, tape_len); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_ready: got %b expected 0", in_ready); end
    endtask

    task automatic test_object();
        doStart();
        pushExp(0, word(8'h7B, 56'd0));
        pushExp(1, word(8'h22, 56'd5));
        pushExp(2, word(8'h74, 56'd0));
        pushExp(3, word(8'h7D, 56'd0));
        pushExp(0, word(8'h7B, 56'd4));
        sendElem(objOpen, 0, 0, 1'b0);
        sendElem(str, 5, 0, 1'b0);
        sendElem(trueVal, 0, 0, 1'b0);
        sendElem(objClose, 0, 0, 1'b1);
        waitSettle();
        checks += 4;
        if (done !== 1'b1)    begin failures++; $display("[TB] FAIL object_done: got %b expected 1", done); end
        if (tape_len !== 3'd4) begin failures++; $display("[TB] FAIL object_len: got %0d expected 4", tape_len); end
        if (err !== 1'b0)     begin failures++; $display("[TB] FAIL object_err: got %b expected 0", err); end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL object_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_number();
        doStart();
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL start_clears_done: got %b expected 0", done); end
        pushExp(0, word(8'h5B, 56'd0));
        pushExp(1, word(8'h75, 56'd0));
        pushExp(2, 64'd42);
        pushExp(3, word(8'h5D, 56'd0));
        pushExp(0, word(8'h5B, 56'd4));
        sendElem(arrayOpen, 0, 0, 1'b0);
        sendElem(unsignedInt, 0, 64'd42, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL num_ready_gap: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL num_ready_back: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        sendElem(arrayClose, 0, 0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL close_ready_gap: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        waitSettle();
        checks += 3;
        if (done !== 1'b1)     begin failures++; $display("[TB] FAIL number_done: got %b expected 1", done); end
        if (tape_len !== 3'd4) begin failures++; $display("[TB] FAIL number_len: got %0d expected 4", tape_len); end
        if (expQ.size() != 0)  begin failures++; $display("[TB] FAIL number_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_mismatch();
        doStart();
        pushExp(0, word(8'h7B, 56'd0));
        sendElem(objOpen, 0, 0, 1'b0);
        sendElem(arrayClose, 0, 0, 1'b0);
        waitSettle();
        checks += 4;
        if (err !== 1'b1 || err_code !== 3'd3) begin failures++; $display("[TB] FAIL mismatch_code: got %b/%0d expected 1/3", err, err_code); end
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_ready: got %b expected 0", in_ready); end
        if (done !== 1'b0)     begin failures++; $display("[TB] FAIL mismatch_done: got %b expected 0", done); end
        if (expQ.size() != 0)  begin failures++; $display("[TB] FAIL mismatch_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_overflow();
        doStart();
        pushExp(0, word(8'h5B, 56'd0));
        pushExp(1, word(8'h5B, 56'd0));
        for (int i = 0; i < 3; i++)
            sendElem(arrayOpen, 0, 0, 1'b0);
        waitSettle();
        checks += 3;
        if (err !== 1'b1 || err_code !== 3'd1) begin failures++; $display("[TB] FAIL overflow_code: got %b/%0d expected 1/1", err, err_code); end
        if (depth !== 2'd2)   begin failures++; $display("[TB] FAIL overflow_depth: got %0d expected 2", depth); end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL overflow_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_full();
        doStart();
        for (int i = 0; i < 4; i++) begin
            pushExp(i, word(8'h74, 56'd0));
            sendElem(trueVal, 0, 0, 1'b0);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL exact_fill_err: got %b expected 0", err); end
        sendElem(trueVal, 0, 0, 1'b0);
        waitSettle();
        checks += 2;
        if (err !== 1'b1 || err_code !== 3'd4) begin failures++; $display("[TB] FAIL full_code: got %b/%0d expected 1/4", err, err_code); end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL full_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_unclosed();
        doStart();
        pushExp(0, word(8'h7B, 56'd0));
        sendElem(objOpen, 0, 0, 1'b1);
        waitSettle();
        checks += 3;
        if (err !== 1'b1 || err_code !== 3'd5) begin failures++; $display("[TB] FAIL unclosed_code: got %b/%0d expected 1/5", err, err_code); end
        if (done !== 1'b0)    begin failures++; $display("[TB] FAIL unclosed_done: got %b expected 0", done); end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL unclosed_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_bad_type();
        doStart();
        sendElem(ElementType'(4'hF), 0, 0, 1'b0);
        waitSettle();
        checks++;
        if (err !== 1'b1 || err_code !== 3'd7) begin failures++; $display("[TB] FAIL badtype_code: got %b/%0d expected 1/7", err, err_code); end
    endtask

    task automatic test_root();
        doStart();
        pushExp(1, word(8'h6E, 56'd0));
        pushExp(2, word(8'h72, 56'd0));
        pushExp(0, word(8'h72, 56'd3));
        sendElem(nullVal, 0, 0, 1'b1);
        waitSettle();
        checks += 3;
        if (done !== 1'b1)     begin failures++; $display("[TB] FAIL root_done: got %b expected 1", done); end
        if (tape_len !== 3'd3) begin failures++; $display("[TB] FAIL root_len: got %0d expected 3", tape_len); end
        if (expQ.size() != 0)  begin failures++; $display("[TB] FAIL root_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_async_reset();
        doStart();
`ifdef STRUCTURE_TAPE_ROOT_EN
        pushExp(1, word(8'h5B, 56'd0));
`else
        pushExp(0, word(8'h5B, 56'd0));
`endif
        sendElem(arrayOpen, 0, 0, 1'b0);
        sendElem(arrayClose, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks += 4;
        if (tape_we !== 1'b0)  begin failures++; $display("[TB] FAIL areset_we: got %b expected 0", tape_we); end
        if (tape_wdata !== '0 || tape_addr !== '0) begin failures++; $display("[TB] FAIL areset_data: got %h@%0d expected 0@0", tape_wdata, tape_addr); end
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL areset_ready: got %b expected 0", in_ready); end
        if (depth !== '0)      begin failures++; $display("[TB] FAIL areset_depth: got %0d expected 0", depth); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks += 2;
        if (in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got ready=%b done=%b expected 0/0", in_ready, done); end
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL areset_pending: got %0d writes missing expected 0", expQ.size()); end
        expQ.delete();
    endtask

    initial begin
        test_reset();
`ifdef STRUCTURE_TAPE_ROOT_EN
        test_root();
`else
        test_object();
        test_number();
        test_mismatch();
        test_overflow();
        test_full();
        test_unclosed();
        test_bad_type();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion by 100000, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
